// File: rtl/led_sdo_rx_if.sv
// Serial LED link plus receive-side results, shared by transmitter/bench and receiver.
//   cko, sdo    : serial bit clock and per-lane data (driven by master)
//   rx_data     : last completed word, lane i at [WORD_W*i +: WORD_W]
//   rx_valid    : one-cycle pulse when rx_data updates
//   rx_word_idx : word index of rx_data within the frame
//   frame_done  : clean frame end pulse
//   frame_err   : short/overrun frame pulse
//   busy        : frame in progress
interface led_sdo_rx_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned WORD_W = 12,
  parameter int unsigned NWORDS = 1
);
  localparam int unsigned IDX_W = $clog2(NWORDS) + 1;

  logic                    cko;
  logic [LANES-1:0]        sdo;
  logic [LANES*WORD_W-1:0] rx_data;
  logic                    rx_valid;
  logic [IDX_W-1:0]        rx_word_idx;
  logic                    frame_done;
  logic                    frame_err;
  logic                    busy;

  modport master (
    output cko, sdo,
    input  rx_data, rx_valid, rx_word_idx, frame_done, frame_err, busy
  );

  modport slave (
    input  cko, sdo,
    output rx_data, rx_valid, rx_word_idx, frame_done, frame_err, busy
  );
endinterface

// File: rtl/led_sdo_rx.sv
// Oversampling receiver for the LED serial output link. Deserialises each
// lane into WORD_W-bit {R,G,B} words and delimits frames by bit count plus
// an idle timeout on cko.
//   clk_fast : oversampling clock (>= 4x cko)
//   rstn     : asynchronous active-low reset
//   bus      : led_sdo_rx_if slave (cko/sdo in, rx_* / frame_* / busy out)
module led_sdo_rx #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned WORD_W  = 12,
  parameter int unsigned NWORDS  = 1,
  parameter int unsigned IDLE_TO = 64
) (
  input  logic         clk_fast,
  input  logic         rstn,
  led_sdo_rx_if.slave  bus
);

  localparam int unsigned BIT_W  = $clog2(WORD_W);
  localparam int unsigned IDX_W  = $clog2(NWORDS) + 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_TO);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]  WORD_FULL = IDX_W'(NWORDS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO - 1);

  typedef enum logic [1:0] {IDLE, RECV, OVERRUN} state_t;

  // Synchroniser / edge-detect stage
  logic             cko_s1, cko_s2, cko_s3;
  logic [LANES-1:0] sdo_s1, sdo_s2;
  logic             edge_q;
  logic [LANES-1:0] sdo_q;
  logic             cko_low_c;

  // Frame state and datapath registers
  state_t                        state, state_n;
  logic [BIT_W-1:0]              bit_cnt, bit_n;
  logic [IDX_W-1:0]              word_cnt, word_n;
  logic [IDLE_W-1:0]             idle_cnt, idle_n;
  logic [LANES-1:0][WORD_W-1:0]  shreg, shreg_n, shifted_c;
  logic [LANES-1:0][WORD_W-1:0]  rx_data, data_n;
  logic                          rx_valid, valid_n;
  logic [IDX_W-1:0]              rx_word_idx, idx_n;
  logic                          frame_done, done_n;
  logic                          frame_err, err_n;
  logic                          busy, busy_n;
  logic                          timeout_c;

  // Two-flop synchronisers on cko and sdo, third cko flop for rise detection.
  // The rise and its data bit are registered together so the FSM sees them aligned.
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      cko_s1 <= 1'b0;
      cko_s2 <= 1'b0;
      cko_s3 <= 1'b0;
      sdo_s1 <= '0;
      sdo_s2 <= '0;
      edge_q <= 1'b0;
      sdo_q  <= '0;
    end else begin
      cko_s1 <= bus.cko;
      cko_s2 <= cko_s1;
      cko_s3 <= cko_s2;
      sdo_s1 <= bus.sdo;
      sdo_s2 <= sdo_s1;
      edge_q <= cko_s2 & ~cko_s3;
      sdo_q  <= sdo_s2;
    end
  end

  assign cko_low_c = ~cko_s3;
  assign timeout_c = cko_low_c && (idle_cnt == IDLE_LAST);

  // Every lane shifted left with its new bit in the LSB
  always_comb begin
    shifted_c = shreg;
    for (int i = 0; i < int'(LANES); i++) begin
      shifted_c[i] = {shreg[i][WORD_W-2:0], sdo_q[i]};
    end
  end

  // State and output registers
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_word_idx <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_n;
      word_cnt    <= word_n;
      idle_cnt    <= idle_n;
      shreg       <= shreg_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      rx_word_idx <= idx_n;
      frame_done  <= done_n;
      frame_err   <= err_n;
      busy        <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    word_n  = word_cnt;
    idle_n  = idle_cnt;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = 1'b0;
    idx_n   = rx_word_idx;
    done_n  = 1'b0;
    err_n   = 1'b0;
    busy_n  = busy;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (edge_q) begin
          state_n = RECV;
          busy_n  = 1'b1;
          shreg_n = shifted_c;
          bit_n   = BIT_W'(1);
          idle_n  = '0;
        end
      end

      RECV: begin
        if (edge_q) begin
          idle_n = '0;
          if (word_cnt == WORD_FULL) begin
            // Extra bits beyond the expected frame length are not captured
            state_n = OVERRUN;
          end else begin
            shreg_n = shifted_c;
            if (bit_cnt == BIT_LAST) begin
              data_n  = shifted_c;
              valid_n = 1'b1;
              idx_n   = word_cnt;
              bit_n   = '0;
              word_n  = word_cnt + IDX_W'(1);
            end else begin
              bit_n = bit_cnt + BIT_W'(1);
            end
          end
        end else if (timeout_c) begin
          if ((word_cnt == WORD_FULL) && (bit_cnt == '0)) begin
            done_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
          busy_n  = 1'b0;
          bit_n   = '0;
          word_n  = '0;
          idle_n  = '0;
          shreg_n = '0;
        end else if (cko_low_c) begin
          idle_n = idle_cnt + IDLE_W'(1);
        end
      end

      OVERRUN: begin
        if (edge_q) begin
          idle_n = '0;
        end else if (timeout_c) begin
          err_n   = 1'b1;
          state_n = IDLE;
          busy_n  = 1'b0;
          bit_n   = '0;
          word_n  = '0;
          idle_n  = '0;
          shreg_n = '0;
        end else if (cko_low_c) begin
          idle_n = idle_cnt + IDLE_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_word_idx = rx_word_idx;
  assign bus.frame_done  = frame_done;
  assign bus.frame_err   = frame_err;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_led_sdo_rx.sv
// Directed bench for led_sdo_rx: one NWORDS=1 receiver and one NWORDS=2
// receiver share the same serial stimulus.
module tb_led_sdo_rx;
  localparam int unsigned LANES  = 8;
  localparam int unsigned WORD_W = 12;
  localparam int unsigned DATA_W = LANES * WORD_W;

  logic             clk_fast = 1'b0;
  logic             rstn     = 1'b0;
  logic             cko      = 1'b0;
  logic [LANES-1:0] sdo      = '0;

  always #5 clk_fast = ~clk_fast;

  led_sdo_rx_if #(.LANES(LANES), .WORD_W(WORD_W), .NWORDS(1)) b1 ();
  led_sdo_rx_if #(.LANES(LANES), .WORD_W(WORD_W), .NWORDS(2)) b2 ();

  assign b1.cko = cko;
  assign b1.sdo = sdo;
  assign b2.cko = cko;
  assign b2.sdo = sdo;

  led_sdo_rx #(.LANES(LANES), .WORD_W(WORD_W), .NWORDS(1), .IDLE_TO(64)) dut1 (
    .clk_fast (clk_fast),
    .rstn     (rstn),
    .bus      (b1.slave)
  );

  led_sdo_rx #(.LANES(LANES), .WORD_W(WORD_W), .NWORDS(2), .IDLE_TO(64)) dut2 (
    .clk_fast (clk_fast),
    .rstn     (rstn),
    .bus      (b2.slave)
  );

  // Cycle counter and pulse monitors
  int cyc = 0;
  always @(posedge clk_fast) cyc <= cyc + 1;

  int v1_cnt = 0, d1_cnt = 0, e1_cnt = 0, v1_cyc = 0;
  int v2_cnt = 0, d2_cnt = 0, e2_cnt = 0;
  logic [DATA_W-1:0] d2_data [2];

  always @(negedge clk_fast) begin
    if (b1.rx_valid) begin
      v1_cnt <= v1_cnt + 1;
      v1_cyc <= cyc;
    end
    if (b1.frame_done) d1_cnt <= d1_cnt + 1;
    if (b1.frame_err)  e1_cnt <= e1_cnt + 1;
    if (b2.rx_valid) begin
      v2_cnt <= v2_cnt + 1;
      d2_data[b2.rx_word_idx[0]] <= b2.rx_data;
    end
    if (b2.frame_done) d2_cnt <= d2_cnt + 1;
    if (b2.frame_err)  e2_cnt <= e2_cnt + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_fast);
  endtask

  // Serial stimulus: cko = clk_fast/8, sdo changes at the start of the low phase
  logic [LANES-1:0]  seq [32];
  logic [WORD_W-1:0] w   [LANES];
  int rise_cyc = 0;

  task automatic send_seq(input int n);
    for (int i = 0; i < n; i++) begin
      cko = 1'b0;
      sdo = seq[i];
      tick(4);
      cko = 1'b1;
      rise_cyc = cyc;
      tick(4);
    end
  endtask

  task automatic idle(input int n);
    cko = 1'b0;
    sdo = '0;
    tick(n);
  endtask

  task automatic load_w(input int base);
    for (int i = 0; i < int'(WORD_W); i++)
      for (int k = 0; k < int'(LANES); k++)
        seq[base+i][k] = w[k][int'(WORD_W)-1-i];
  endtask

  function automatic logic [DATA_W-1:0] pack_w();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(LANES); k++) r[k*int'(WORD_W) +: WORD_W] = w[k];
    return r;
  endfunction

  int bv1, bd1, be1, bv2, bd2, be2;

  task automatic snap();
    bv1 = v1_cnt; bd1 = d1_cnt; be1 = e1_cnt;
    bv2 = v2_cnt; bd2 = d2_cnt; be2 = e2_cnt;
  endtask

  logic [DATA_W-1:0] exp1, exp2, exp20, exp21, exp4;
  logic [3:0]        v;

  initial begin
    // Reset state
    tick(3);
    chk("rst_rx_data",  b1.rx_data, '0);
    chk("rst_rx_valid", DATA_W'(b1.rx_valid), '0);
    chk("rst_word_idx", DATA_W'(b1.rx_word_idx), '0);
    chk("rst_done",     DATA_W'(b1.frame_done), '0);
    chk("rst_err",      DATA_W'(b1.frame_err), '0);
    chk("rst_busy",     DATA_W'(b1.busy), '0);
    rstn = 1'b1;
    tick(4);

    // Single clean frame: lane k carries {k+1,k+1,k+1}
    for (int k = 0; k < int'(LANES); k++) begin
      v = 4'(k + 1);
      w[k] = {v, v, v};
    end
    exp1 = pack_w();
    load_w(0);
    snap();
    send_seq(12);
    chk("t1_busy_high", DATA_W'(b1.busy), DATA_W'(1));
    idle(100);
    chk("t1_latency",   DATA_W'(v1_cyc - rise_cyc), DATA_W'(4));
    chk("t1_valid_cnt", DATA_W'(v1_cnt - bv1), DATA_W'(1));
    chk("t1_word_idx",  DATA_W'(b1.rx_word_idx), '0);
    chk("t1_rx_data",   b1.rx_data, exp1);
    chk("t1_lane7",     DATA_W'(b1.rx_data[DATA_W-1 -: WORD_W]), DATA_W'(12'h888));
    chk("t1_done_cnt",  DATA_W'(d1_cnt - bd1), DATA_W'(1));
    chk("t1_err_cnt",   DATA_W'(e1_cnt - be1), '0);
    chk("t1_busy_low",  DATA_W'(b1.busy), '0);

    // Short frame: 7 bits then idle
    for (int i = 0; i < 7; i++) seq[i] = '1;
    snap();
    send_seq(7);
    idle(100);
    chk("short_err_cnt",   DATA_W'(e1_cnt - be1), DATA_W'(1));
    chk("short_valid_cnt", DATA_W'(v1_cnt - bv1), '0);
    chk("short_done_cnt",  DATA_W'(d1_cnt - bd1), '0);
    chk("short_rx_data",   b1.rx_data, exp1);

    // Overrun: 13 bits into a one-word receiver
    for (int k = 0; k < int'(LANES); k++) w[k] = 12'hA50 + 12'(k);
    exp2 = pack_w();
    load_w(0);
    seq[12] = 8'h55;
    snap();
    send_seq(13);
    idle(100);
    chk("ovr_valid_cnt", DATA_W'(v1_cnt - bv1), DATA_W'(1));
    chk("ovr_rx_data",   b1.rx_data, exp2);
    chk("ovr_err_cnt",   DATA_W'(e1_cnt - be1), DATA_W'(1));
    chk("ovr_done_cnt",  DATA_W'(d1_cnt - bd1), '0);

    // Two words per lane on the NWORDS=2 receiver
    for (int k = 0; k < int'(LANES); k++) w[k] = 12'hABC ^ 12'(k);
    exp20 = pack_w();
    load_w(0);
    for (int k = 0; k < int'(LANES); k++) w[k] = 12'h123 + 12'(k);
    exp21 = pack_w();
    load_w(12);
    snap();
    send_seq(24);
    idle(100);
    chk("nw2_valid_cnt", DATA_W'(v2_cnt - bv2), DATA_W'(2));
    chk("nw2_word0",     d2_data[0], exp20);
    chk("nw2_word0_l0",  DATA_W'(d2_data[0][11:0]), DATA_W'(12'hABC));
    chk("nw2_word1",     d2_data[1], exp21);
    chk("nw2_last_idx",  DATA_W'(b2.rx_word_idx), DATA_W'(1));
    chk("nw2_done_cnt",  DATA_W'(d2_cnt - bd2), DATA_W'(1));
    chk("nw2_err_cnt",   DATA_W'(e2_cnt - be2), '0);

    // Reset after 5 bits, then a clean frame
    for (int k = 0; k < int'(LANES); k++) w[k] = 12'h7E0 ^ 12'(k * 3);
    load_w(0);
    send_seq(5);
    rstn = 1'b0;
    tick(1);
    chk("mrst_rx_data",  b1.rx_data, '0);
    chk("mrst_busy",     DATA_W'(b1.busy), '0);
    chk("mrst_valid",    DATA_W'(b1.rx_valid), '0);
    chk("mrst_err",      DATA_W'(b1.frame_err), '0);
    chk("mrst_done",     DATA_W'(b1.frame_done), '0);
    chk("mrst_rx_data2", b2.rx_data, '0);
    cko = 1'b0;
    sdo = '0;
    tick(1);
    rstn = 1'b1;
    tick(4);
    for (int k = 0; k < int'(LANES); k++) w[k] = 12'h3C0 | 12'(k);
    exp4 = pack_w();
    load_w(0);
    snap();
    send_seq(12);
    idle(100);
    chk("mrst_valid_cnt", DATA_W'(v1_cnt - bv1), DATA_W'(1));
    chk("mrst_new_data",  b1.rx_data, exp4);
    chk("mrst_err_cnt",   DATA_W'(e1_cnt - be1), '0);
    chk("mrst_done_cnt",  DATA_W'(d1_cnt - bd1), DATA_W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_sdo_rx.md
Name: led_sdo_rx

Overview:
- Receive-side counterpart of the LED serial output path.
- Oversamples the serial link (cko, sdo[LANES-1:0]) on the fast clock and deserialises each lane back into 12-bit {R,G,B} words.
- Frames are delimited by bit count plus an idle timeout on cko.
- Serves as the LED-driver side model and as a loopback checker inside the LED controller design.

Parameters:
- LANES, 8, number of parallel serial data lanes (sdo width).
- WORD_W, 12, bits per word per lane; fixed {R[3:0],G[3:0],B[3:0]}.
- NWORDS, 1, words per lane per frame (LEDs chained per lane).
- IDLE_TO, 64, clk_fast cycles of cko low that end a frame.

Ports:
- clk_fast  in  1  oversampling clock; must be ≥4x the cko frequency.
- rstn  in  1  asynchronous active-low reset.
- cko  in  1  serial bit clock from the transmitter; idles low; asynchronous to clk_fast.
- sdo  in  LANES  serial data, MSB first; stable around the cko rising edge.
- rx_data  out  LANES*WORD_W  last completed word; lane i occupies [12i+11:12i]; bits [11:8]=R, [7:4]=G, [3:0]=B.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_word_idx  out  clog2(NWORDS)+1  index of the word in rx_data within the current frame, 0-based.
- frame_done  out  1  one-cycle pulse when a frame completes cleanly.
- frame_err  out  1  one-cycle pulse on a short or overrun frame.
- busy  out  1  high from the first cko rise of a frame until the frame ends.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_word_idx=0, frame_done=0, frame_err=0, busy=0, and all internal counters cleared. Reset mid-frame discards the partial word, and no pulses are generated.
- Synchronisation: cko and sdo each pass through a 2-flop synchroniser of identical depth, plus one further register on cko for edge detection. A rising edge is declared when the delayed synced cko=0 and the synced cko=1. sdo is sampled from the same synced stage in that cycle.
- Shift: on each rising edge, every lane shifts left and takes its synced sdo bit into bit 0; bit_cnt increments.
- Word complete: when bit_cnt reaches WORD_W-1 and a rising edge occurs:
  - the shift registers (including the new bit) load into rx_data;
  - rx_valid pulses with rx_word_idx = current word_cnt;
  - bit_cnt returns to 0 and word_cnt increments.
- Latency: rx_valid asserts 3 clk_fast cycles after the first clk_fast edge that samples cko high for the last bit.
- States: IDLE, RECV, OVERRUN.
  - IDLE: busy=0. The first rising edge moves to RECV, asserts busy and shifts the bit. Counters are already 0.
  - RECV: idle_cnt resets on every cko rise and increments while synced cko is low. On idle_cnt==IDLE_TO-1:
    - if word_cnt==NWORDS and bit_cnt==0, pulse frame_done;
    - otherwise pulse frame_err (short frame; the partial word is dropped and rx_data is unchanged).
    - Either way, clear the counters and go to IDLE.
  - RECV, word_cnt==NWORDS: a further rising edge before timeout moves to OVERRUN. Its bits are not shifted and rx_valid is not generated.
  - OVERRUN: ignore edges; on idle timeout pulse frame_err (never frame_done), clear, go to IDLE.
- Pulse priority: frame_done/frame_err pulse in the timeout cycle only. rx_valid and the timeout pulse cannot coincide, because the timeout requires cko low for IDLE_TO cycles.
- Idle counting: idle_cnt saturates at IDLE_TO-1 and is not counted in IDLE.
- cko held high indefinitely: no timeout; the block waits.
- Glitches: the cko high or low phase must last ≥2 clk_fast cycles. Shorter pulses are outside the spec and are not required to be detected.
- Hold: rx_data holds its value until the next completed word.

Test Plan:
- Single frame, NWORDS=1: lane k sends 12'h{k+1}{k+1}{k+1} MSB first at cko = clk_fast/8, then cko low ≥64 cycles. Expected:
  - one rx_valid with rx_word_idx=0;
  - rx_data lane0=12'h111 … lane7=12'h888;
  - frame_done one cycle after 64 low cycles;
  - frame_err=0 and busy falls.
- Latency: after the 12th cko rise, rx_valid is exactly 3 clk_fast cycles after the first sampling edge that sees cko=1.
- Short frame: 7 bits, then idle. Expected frame_err pulses once, there is no rx_valid, and rx_data is unchanged from its previous value.
- Overrun: 13 bits with NWORDS=1. Expected one rx_valid after bit 12 with correct data, then frame_err at timeout, and no frame_done.
- NWORDS=2: 24 bits per lane (0xABC then 0x123 on lane0). Expected:
  - rx_valid with idx 0 and lane0=12'hABC;
  - then rx_valid with idx 1 and lane0=12'h123;
  - then frame_done.
- Reset mid-frame: rstn low after bit 5 for 2 cycles, then a full clean frame. Expected all outputs 0 during reset, a single correct rx_valid for the new frame, and no frame_err.
